// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the dual-port SPI NOR flash read controller.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } spi_rd_state_e;

  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam int         SPI_ADDR_W        = 24;
  localparam int         SPI_WORD_W        = 32;

  // The serial stream arrives first byte in the top byte; the word wants it in [7:0].
  function automatic logic [SPI_WORD_W-1:0] spi_word_from_stream(input logic [SPI_WORD_W-1:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin grant with last-grant memory; grants only while enabled.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  logic last_grant_reg;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req_valid == 2'b11) begin
        grant = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  // A grant always coincides with an accept, so it is the update condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (grant[0]) begin
      last_grant_reg <= 1'b0;
    end else if (grant[1]) begin
      last_grant_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_rd_arb.sv
// Read-only SPI (mode 0) flash controller shared by two word requesters.
// SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_rd_arb
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [SPI_ADDR_W-1:0] req0_addr,
  output logic                  rsp0_valid,
  output logic [SPI_WORD_W-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [SPI_ADDR_W-1:0] req1_addr,
  output logic                  rsp1_valid,
  output logic [SPI_WORD_W-1:0] rsp1_data,
  output logic                  spi_clk,
  output logic                  spi_cs,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CSI_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CSI_W-1:0] CSI_RELOAD = CSI_W'(CS_IDLE - 1);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] RD_CMD = SPI_CMD_FAST_READ;
`else
  localparam logic [7:0] RD_CMD = SPI_CMD_READ;
`endif

  spi_rd_state_e         state_reg;
  logic                  spi_clk_reg;
  logic                  cs_reg;
  logic                  mosi_reg;
  logic [DIV_W-1:0]      div_reg;
  logic [5:0]            bit_reg;
  logic [CSI_W-1:0]      done_reg;
  logic [31:0]           tx_reg;
  logic [SPI_WORD_W-1:0] rx_reg;
  logic                  id_reg;

  logic [1:0]            grant;
  logic                  accept;
  logic                  finish;
  logic [SPI_ADDR_W-1:0] addr_sel;
  logic                  unused_addr_lsbs;

  spi_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_reg == IDLE),
    .req_valid ({req1_valid, req0_valid}),
    .grant     (grant)
  );

  assign accept           = |grant;
  assign addr_sel         = grant[1] ? req1_addr : req0_addr;
  assign unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

  // Transaction ends on the falling spi_clk edge that follows the 32nd data bit.
  assign finish = (state_reg == DATA) && (div_reg == '0) && spi_clk_reg && (bit_reg == 6'd32);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      spi_clk_reg <= 1'b0;
      cs_reg      <= 1'b1;
      mosi_reg    <= 1'b0;
      div_reg     <= '0;
      bit_reg     <= '0;
      done_reg    <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      id_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg    <= grant[1];
            cs_reg    <= 1'b0;
            mosi_reg  <= RD_CMD[7];
            tx_reg    <= {RD_CMD[6:0], addr_sel[23:2], 2'b00, 1'b0};
            div_reg   <= DIV_RELOAD;
            bit_reg   <= '0;
            state_reg <= CMD;
          end
        end
        DONE: begin
          if (done_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            done_reg <= done_reg - 1'b1;
          end
        end
        default: begin
          if (div_reg != '0) begin
            div_reg <= div_reg - 1'b1;
          end else begin
            div_reg <= DIV_RELOAD;
            if (!spi_clk_reg) begin
              spi_clk_reg <= 1'b1;
              bit_reg     <= bit_reg + 6'd1;
              if (state_reg == DATA) begin
                rx_reg <= {rx_reg[SPI_WORD_W-2:0], spi_miso};
              end
              case (state_reg)
                CMD: begin
                  if (bit_reg == 6'd7) begin
                    state_reg <= ADDR;
                    bit_reg   <= '0;
                  end
                end
                ADDR: begin
                  if (bit_reg == 6'd23) begin
`ifdef SPI_FLASH_FAST_READ_EN
                    state_reg <= DUMMY;
`else
                    state_reg <= DATA;
`endif
                    bit_reg   <= '0;
                  end
                end
                DUMMY: begin
                  if (bit_reg == 6'd7) begin
                    state_reg <= DATA;
                    bit_reg   <= '0;
                  end
                end
                default: ;
              endcase
            end else begin
              spi_clk_reg <= 1'b0;
              if (finish) begin
                cs_reg    <= 1'b1;
                mosi_reg  <= 1'b0;
                done_reg  <= CSI_RELOAD;
                state_reg <= DONE;
              end else begin
                // Drained bits shift in as zeros, which also covers the dummy phase.
                mosi_reg <= tx_reg[31];
                tx_reg   <= {tx_reg[30:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      logic                  valid_reg;
      logic [SPI_WORD_W-1:0] data_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= finish && (id_reg == 1'(gi));
          if (finish && (id_reg == 1'(gi))) begin
            data_reg <= spi_word_from_stream(rx_reg);
          end
        end
      end
    end
  endgenerate

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = g_rsp[0].valid_reg;
  assign rsp0_data  = g_rsp[0].data_reg;
  assign rsp1_valid = g_rsp[1].valid_reg;
  assign rsp1_data  = g_rsp[1].data_reg;
  assign spi_clk    = spi_clk_reg;
  assign spi_cs     = cs_reg;
  assign spi_mosi   = mosi_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_flash_rd_arb.sv
// Scoreboard bench for spi_flash_rd_arb with a behavioural mode-0 flash model.
module tb_spi_flash_rd_arb;

  localparam int CLK_DIV = 2;
  localparam int CS_IDLE = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         HDR     = 40;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int         HDR     = 32;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif
  localparam int LAT = (HDR + 32) * 2 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_addr, req1_addr;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        spi_clk, spi_cs, spi_mosi;
  logic        spi_miso = 1'b0;
  logic        busy;

  spi_flash_rd_arb #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int rsp_cnt = 0;
  int acc_cnt [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Flash contents
  logic [7:0] mem [int];

  function automatic logic [7:0] rd_byte(input logic [23:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'hFF;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {rd_byte(b + 24'd3), rd_byte(b + 24'd2), rd_byte(b + 24'd1), rd_byte(b)};
  endfunction

  // Mode-0 flash model: latch mosi on spi_clk rise, drive miso on fall
  int          fl_cnt = 0;
  logic [31:0] fl_hdr = '0;
  logic [7:0]  cap_cmd = '0;
  logic [23:0] cap_addr = '0;

  always @(negedge spi_cs) fl_cnt = 0;

  always @(posedge spi_clk) begin
    if (!spi_cs) begin
      fl_hdr = {fl_hdr[30:0], spi_mosi};
      fl_cnt++;
      if (fl_cnt == 8)  cap_cmd  = fl_hdr[7:0];
      if (fl_cnt == 32) cap_addr = fl_hdr[23:0];
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_cs && fl_cnt >= HDR && fl_cnt < HDR + 32) begin
      int d;
      logic [7:0] b;
      d = fl_cnt - HDR;
      b = rd_byte(cap_addr + 24'(d / 8));
      spi_miso = b[7 - (d % 8)];
    end
  end

  // Scoreboard
  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
    logic [23:0] addr;
  } sb_t;

  sb_t sb_q [$];
  int  grant_q [$];

  logic [1:0]  v_vec, r_vec;
  logic [23:0] a_arr [2];
  assign v_vec = {req1_valid, req0_valid};
  assign r_vec = {req1_ready, req0_ready};
  assign a_arr[0] = req0_addr;
  assign a_arr[1] = req1_addr;

  int cs_gap  = 0;
  bit cs_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (v_vec[p] && r_vec[p]) begin
          if (grant_q.size() > 0) chk("grant_port", 32'(p), 32'(grant_q.pop_front()));
          else chk("grant_unplanned", 32'(p), 32'hFFFF_FFFF);
          sb_q.push_back('{port: p, data: exp_word(a_arr[p]), cyc: cyc,
                           addr: {a_arr[p][23:2], 2'b00}});
          acc_cnt[p]++;
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        int gp;
        logic [31:0] gd;
        gp = rsp1_valid ? 1 : 0;
        gd = rsp1_valid ? rsp1_data : rsp0_data;
        if (rsp0_valid && rsp1_valid) chk("rsp_both", 32'd1, 32'd0);
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(gp), 32'hFFFF_FFFF);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("rsp_port", 32'(gp), 32'(e.port));
          chk("rsp_data", gd, e.data);
          chk("rsp_latency", 32'(cyc - e.cyc), 32'(LAT));
          chk("mosi_cmd", {24'd0, cap_cmd}, {24'd0, EXP_CMD});
          chk("mosi_addr", {8'd0, cap_addr}, {8'd0, e.addr});
          $display("rsp port=%0d addr=%06h data=%08h lat=%0d", gp, e.addr, gd, cyc - e.cyc);
        end
        rsp_cnt++;
      end
      if (spi_cs) begin
        cs_gap++;
      end else if (cs_gap > 0) begin
        if (cs_prev) chk("cs_gap_min", 32'(cs_gap >= CS_IDLE), 32'd1);
        cs_gap  = 0;
        cs_prev = 1'b1;
      end
    end
  end

  task automatic wait_acc(input int p, input int target);
    int n = 0;
    while (acc_cnt[p] < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt[p] < target) chk("accept_timeout", 32'(acc_cnt[p]), 32'(target));
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_count", 32'(rsp_cnt), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h000100] = 8'h11; mem[32'h000101] = 8'h22;
    mem[32'h000102] = 8'h33; mem[32'h000103] = 8'h44;
    mem[32'h000200] = 8'hDD; mem[32'h000201] = 8'hCC;
    mem[32'h000202] = 8'hBB; mem[32'h000203] = 8'hAA;
    mem[32'h000300] = 8'hFF; mem[32'h000301] = 8'h00;
    mem[32'h000302] = 8'hFF; mem[32'h000303] = 8'h00;
    mem[32'hFFFFFC] = 8'h01; mem[32'hFFFFFD] = 8'h02;
    mem[32'hFFFFFE] = 8'h03; mem[32'hFFFFFF] = 8'h04;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_spi_clk", {31'd0, spi_clk}, 32'd0);
    chk("rst_spi_cs", {31'd0, spi_cs}, 32'd1);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Contention: port 0 wins the first tie, then port 1
    req0_addr = 24'h000200; req1_addr = 24'h000300;
    grant_q.push_back(0); grant_q.push_back(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(0, 1); req0_valid = 1'b0;
    wait_acc(1, 1); req1_valid = 1'b0;
    wait_rsp(2);

    // Single read with unaligned address
    req0_addr = 24'h000101;
    grant_q.push_back(0);
    req0_valid = 1'b1;
    wait_acc(0, 2); req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_active", {31'd0, busy}, 32'd1);
    wait_rsp(3);
    chk("rsp1_hold", rsp1_data, 32'h00FF00FF);

    // Port 0 held high, port 1 joins during the first transfer
    req0_addr = 24'h000100; req1_addr = 24'h000300;
    grant_q.push_back(0); grant_q.push_back(1);
    grant_q.push_back(0); grant_q.push_back(1);
    req0_valid = 1'b1;
    wait_acc(0, 3);
    repeat (50) @(negedge clk);
    req1_valid = 1'b1;
    wait_acc(0, 4); req0_valid = 1'b0;
    wait_acc(1, 3); req1_valid = 1'b0;
    wait_rsp(7);

    // Top-of-flash word
    req1_addr = 24'hFFFFFE;
    grant_q.push_back(1);
    req1_valid = 1'b1;
    wait_acc(1, 4); req1_valid = 1'b0;
    wait_rsp(8);
    chk("rsp1_wrap", rsp1_data, 32'h04030201);

    // Asynchronous reset part-way through the data phase
    req0_addr = 24'h000100;
    grant_q.push_back(0);
    req0_valid = 1'b1;
    wait_acc(0, 5); req0_valid = 1'b0;
    begin
      int n = 0;
      while (fl_cnt < 40 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("reach_40_edges", 32'(fl_cnt >= 40), 32'd1);
    end
    #1 reset = 1'b1;
    #1;
    chk("abort_cs", {31'd0, spi_cs}, 32'd1);
    chk("abort_spi_clk", {31'd0, spi_clk}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rsp1_data", rsp1_data, 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt), 32'd8);

    // Recovery read
    grant_q.push_back(0);
    req0_valid = 1'b1;
    wait_acc(0, 6); req0_valid = 1'b0;
    wait_rsp(9);
    chk("rsp0_final", rsp0_data, 32'h44332211);
    chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
    chk("sb_q_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
